// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Decides when the ID-stage instruction must be held back because an older
// instruction has not produced one of its source registers yet. It also
// decides when a taken branch or jump may flush the fetch stream, and keeps
// saturating statistics of stall and flush cycles.
//
// Parameters
//   CNT_W          width of the StallCount / FlushCount statistics counters
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   IFID_OpCode    opcode of the instruction in ID
//   IFID_Rs/Rt     source register fields of the instruction in ID
//   IDEX_MemRead   EX-stage instruction is a load
//   IDEX_RegWrite  EX-stage instruction writes a register
//   IDEX_Rd        EX-stage destination register (after the RegDst mux)
//   EXMEM_MemRead  MEM-stage instruction is a load
//   EXMEM_Rd       MEM-stage destination register
//   PCSrc, IsJ     ID-stage branch-taken / jump indications
//   PCWrite        PC write enable (low while stalling)
//   IFIDWrite      IF/ID write enable (low while stalling)
//   IDEX_Bubble    injects zero control into ID/EX (high while stalling)
//   IF_Flush       clears IF/ID and redirects fetch
//   StallCount     saturating count of stall cycles
//   FlushCount     saturating count of flush cycles
//   State          current FSM state (00 RUN, 01 HOLD, 10 REEVAL)

module hazard_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       IFID_OpCode,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_Rd,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_Rd,
    input  logic             PCSrc,
    input  logic             IsJ,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IF_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HOLD   = 2'b01,
        REEVAL = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic             uses_rs;
    logic             uses_rt;
    logic             is_branch;
    logic             match_ex;
    logic             match_mem;
    logic [1:0]       need;
    logic             stall;
    logic             flush;

    // Decode which source fields the ID instruction actually reads, then
    // rank the hazards. A branch behind a load needs two cycles because the
    // loaded value only exists after MEM, and the branch compares in ID.
    // Register 0 never carries a dependency.
    always_comb begin
        uses_rs   = (IFID_OpCode != OP_J);
        uses_rt   = (IFID_OpCode == OP_RTYPE) || (IFID_OpCode == OP_BEQ) ||
                    (IFID_OpCode == OP_BNE)   || (IFID_OpCode == OP_SW);
        is_branch = (IFID_OpCode == OP_BEQ) || (IFID_OpCode == OP_BNE);

        match_ex  = (IDEX_Rd != 5'd0) &&
                    ((uses_rs && (IFID_Rs == IDEX_Rd)) ||
                     (uses_rt && (IFID_Rt == IDEX_Rd)));
        match_mem = (EXMEM_Rd != 5'd0) &&
                    ((uses_rs && (IFID_Rs == EXMEM_Rd)) ||
                     (uses_rt && (IFID_Rt == EXMEM_Rd)));

        need = 2'd0;
        if (is_branch && IDEX_MemRead && match_ex) begin
            need = 2'd2;
        end else if (IDEX_MemRead && match_ex) begin
            need = 2'd1;
        end else if (is_branch && IDEX_RegWrite && match_ex) begin
            need = 2'd1;
        end else if (is_branch && EXMEM_MemRead && match_mem) begin
            need = 2'd1;
        end
    end

    // Next state and Mealy stall. REEVAL is a RUN that follows a stall, so
    // hazards are looked at again with the pipeline's new contents. HOLD is
    // the forced second cycle of a two-cycle stall. The unused encoding
    // drops back to RUN. Reset overrides the stall so the pipeline enables
    // read as idle while rst is high.
    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        case (state_q)
            RUN, REEVAL: begin
                stall = (need != 2'd0);
                case (need)
                    2'd2:    state_d = HOLD;
                    2'd1:    state_d = REEVAL;
                    default: state_d = RUN;
                endcase
            end
            HOLD: begin
                stall   = 1'b1;
                state_d = REEVAL;
            end
            default: begin
                stall   = 1'b0;
                state_d = RUN;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // A redirect is only honoured when the ID instruction actually advances;
    // during a stall the branch decision is not yet valid.
    always_comb begin
        flush = (PCSrc || IsJ) && !stall && !rst;
    end

    // Saturating statistics: once all-ones they stay there.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign PCWrite     = !stall;
    assign IFIDWrite   = !stall;
    assign IDEX_Bubble = stall;
    assign IF_Flush    = flush;
    assign StallCount  = stall_count_q;
    assign FlushCount  = flush_count_q;
    assign State       = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
//
// Drives directed pipeline scenarios and a randomized stream into two copies
// of the controller (16-bit and 4-bit counters) and compares them against a
// behavioural model built from the hazard rules.

module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [4:0]  rs, rt, idex_rd, exmem_rd;
    logic        idex_mr, idex_rw, exmem_mr, pcsrc, isj;

    logic        pcw, ifidw, bub, flush;
    logic [15:0] sc, fc;
    logic [1:0]  st;
    logic        pcw4, ifidw4, bub4, flush4;
    logic [3:0]  sc4, fc4;
    logic [1:0]  st4;

    int errors = 0;
    int checks = 0;

    // Model state: 0 free-running, 1 forced second stall, 2 re-check
    int m_state;
    int m_sc, m_fc, m_sc4, m_fc4;
    bit e_stall, e_flush;
    int e_next;
    logic [5:0]  e_ctrl;
    logic [39:0] e_cnt;

    hazard_stall_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .IFID_OpCode(op), .IFID_Rs(rs), .IFID_Rt(rt),
        .IDEX_MemRead(idex_mr), .IDEX_RegWrite(idex_rw), .IDEX_Rd(idex_rd),
        .EXMEM_MemRead(exmem_mr), .EXMEM_Rd(exmem_rd), .PCSrc(pcsrc), .IsJ(isj),
        .PCWrite(pcw), .IFIDWrite(ifidw), .IDEX_Bubble(bub), .IF_Flush(flush),
        .StallCount(sc), .FlushCount(fc), .State(st)
    );

    hazard_stall_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .IFID_OpCode(op), .IFID_Rs(rs), .IFID_Rt(rt),
        .IDEX_MemRead(idex_mr), .IDEX_RegWrite(idex_rw), .IDEX_Rd(idex_rd),
        .EXMEM_MemRead(exmem_mr), .EXMEM_Rd(exmem_rd), .PCSrc(pcsrc), .IsJ(isj),
        .PCWrite(pcw4), .IFIDWrite(ifidw4), .IDEX_Bubble(bub4), .IF_Flush(flush4),
        .StallCount(sc4), .FlushCount(fc4), .State(st4)
    );

    always #5 clk = ~clk;

    function automatic bit reads_reg(logic [4:0] x);
        bit u_rs;
        bit u_rt;
        u_rs = (op != 6'b000010);
        u_rt = (op == 6'b000000) || (op == 6'b000100) ||
               (op == 6'b000101) || (op == 6'b101011);
        return (x != 5'd0) && ((u_rs && rs == x) || (u_rt && rt == x));
    endfunction

    function automatic int need_of();
        bit br;
        br = (op == 6'b000100) || (op == 6'b000101);
        if (br && idex_mr && reads_reg(idex_rd)) return 2;
        if (idex_mr && reads_reg(idex_rd)) return 1;
        if (br && idex_rw && reads_reg(idex_rd)) return 1;
        if (br && exmem_mr && reads_reg(exmem_rd)) return 1;
        return 0;
    endfunction

    function automatic logic [5:0] obs_ctrl();
        return {pcw, ifidw, bub, flush, st};
    endfunction

    function automatic logic [39:0] obs_cnt();
        return {sc, fc, sc4, fc4};
    endfunction

    // Expected outputs for the current inputs and model state
    task automatic predict();
        int n;
        n = need_of();
        if (rst) begin
            e_stall = 1'b0;
            e_next  = 0;
        end else if (m_state == 1) begin
            e_stall = 1'b1;
            e_next  = 2;
        end else begin
            e_stall = (n != 0);
            e_next  = (n == 2) ? 1 : ((n == 1) ? 2 : 0);
        end
        e_flush = (pcsrc || isj) && !e_stall && !rst;
        e_ctrl  = {!e_stall, !e_stall, e_stall, e_flush, 2'(m_state)};
        e_cnt   = {16'(m_sc), 16'(m_fc), 4'(m_sc4), 4'(m_fc4)};
    endtask

    // Take the next rising edge and move the model with it
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            m_state = e_next;
            if (e_stall) begin
                if (m_sc < 65535) m_sc++;
                if (m_sc4 < 15) m_sc4++;
            end
            if (e_flush) begin
                if (m_fc < 65535) m_fc++;
                if (m_fc4 < 15) m_fc4++;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    endtask

    task automatic set_idle();
        op = 6'b000000; rs = 5'd1; rt = 5'd2;
        idex_mr = 1'b0; idex_rw = 1'b0; idex_rd = 5'd0;
        exmem_mr = 1'b0; exmem_rd = 5'd0;
        pcsrc = 1'b0; isj = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        op = 6'b000000; rs = 5'd8; rt = 5'd3;
        idex_mr = 1'b1; idex_rw = 1'b1; idex_rd = 5'd8;
        exmem_mr = 1'b0; exmem_rd = 5'd0; pcsrc = 1'b1; isj = 1'b1;
        #1;
        checks++;
        if (obs_ctrl() !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want %b", obs_ctrl(), 6'b110000);
        end
        checks++;
        if (obs_cnt() !== 40'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %h want 0", obs_cnt());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_cnt() !== 40'd0 || st !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_hold: cnt %h st %b want 0/00", obs_cnt(), st);
        end
        rst = 1'b0;
        set_idle();
        predict();
        advance();
    endtask

    task automatic test_load_use();
        logic [1:0] exp_st [3];
        logic       exp_pcw [3];
        int         sc0;
        exp_st  = '{2'b00, 2'b10, 2'b00};
        exp_pcw = '{1'b0, 1'b1, 1'b1};
        sc0 = int'(sc);
        for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c < 2) begin rs = 5'd8; rt = 5'd3; end
            if (c == 0) begin idex_mr = 1'b1; idex_rw = 1'b1; idex_rd = 5'd8; end
            if (c == 2) begin idex_rw = 1'b1; idex_rd = 5'd10; end
            @(negedge clk);
            predict();
            checks++;
            if (obs_ctrl() !== e_ctrl) begin
                errors++;
                $display("[TB] FAIL load_use_ctrl c%0d: got %b want %b", c, obs_ctrl(), e_ctrl);
            end
            checks++;
            if (st !== exp_st[c] || pcw !== exp_pcw[c]) begin
                errors++;
                $display("[TB] FAIL load_use_seq c%0d: st %b pcw %b want %b %b", c, st, pcw, exp_st[c], exp_pcw[c]);
            end
            advance();
        end
        checks++;
        if (int'(sc) !== sc0 + 1) begin
            errors++;
            $display("[TB] FAIL load_use_count: got %0d want %0d", sc, sc0 + 1);
        end
    endtask

    task automatic test_branch_after_load();
        logic [1:0] exp_st [4];
        logic       exp_pcw [4];
        logic       exp_fl [4];
        exp_st  = '{2'b00, 2'b01, 2'b10, 2'b00};
        exp_pcw = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_fl  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            set_idle();
            if (c < 3) begin op = 6'b000100; rs = 5'd5; rt = 5'd9; end
            if (c == 0) begin idex_mr = 1'b1; idex_rw = 1'b1; idex_rd = 5'd9; end
            if (c == 1) begin exmem_mr = 1'b1; exmem_rd = 5'd9; end
            if (c == 1 || c == 2) pcsrc = 1'b1;
            @(negedge clk);
            predict();
            checks++;
            if (obs_ctrl() !== e_ctrl || obs_cnt() !== e_cnt) begin
                errors++;
                $display("[TB] FAIL branch_load_model c%0d: ctrl %b cnt %h want %b %h", c, obs_ctrl(), obs_cnt(), e_ctrl, e_cnt);
            end
            checks++;
            if (st !== exp_st[c] || pcw !== exp_pcw[c] || flush !== exp_fl[c]) begin
                errors++;
                $display("[TB] FAIL branch_load_seq c%0d: st %b pcw %b fl %b want %b %b %b", c, st, pcw, flush, exp_st[c], exp_pcw[c], exp_fl[c]);
            end
            advance();
        end
    endtask

    task automatic test_reg_zero();
        for (int c = 0; c < 2; c++) begin
            set_idle();
            rs = 5'd0; rt = 5'd0;
            idex_mr = 1'b1; idex_rw = 1'b1; idex_rd = 5'd0;
            @(negedge clk);
            predict();
            checks++;
            if (pcw !== 1'b1 || bub !== 1'b0 || obs_ctrl() !== e_ctrl) begin
                errors++;
                $display("[TB] FAIL reg_zero c%0d: ctrl %b want %b pcw 1", c, obs_ctrl(), e_ctrl);
            end
            advance();
        end
    endtask

    task automatic test_jump();
        int fc0;
        fc0 = int'(fc);
        for (int c = 0; c < 2; c++) begin
            set_idle();
            if (c == 0) begin
                op = 6'b000010; rs = 5'd8; isj = 1'b1;
                idex_mr = 1'b1; idex_rd = 5'd8;
            end
            @(negedge clk);
            predict();
            checks++;
            if (obs_ctrl() !== e_ctrl) begin
                errors++;
                $display("[TB] FAIL jump_ctrl c%0d: got %b want %b", c, obs_ctrl(), e_ctrl);
            end
            checks++;
            if (flush !== (c == 0) || pcw !== 1'b1) begin
                errors++;
                $display("[TB] FAIL jump_flush c%0d: flush %b pcw %b want %b 1", c, flush, pcw, c == 0);
            end
            advance();
        end
        checks++;
        if (int'(fc) !== fc0 + 1) begin
            errors++;
            $display("[TB] FAIL jump_count: got %0d want %0d", fc, fc0 + 1);
        end
    endtask

    task automatic test_saturation();
        int sc0;
        sc0 = int'(sc);
        for (int c = 0; c < 20; c++) begin
            set_idle();
            rs = 5'd8; idex_mr = 1'b1; idex_rd = 5'd8;
            @(negedge clk);
            predict();
            checks++;
            if (obs_ctrl() !== e_ctrl || obs_cnt() !== e_cnt) begin
                errors++;
                $display("[TB] FAIL saturation_model c%0d: ctrl %b cnt %h want %b %h", c, obs_ctrl(), obs_cnt(), e_ctrl, e_cnt);
            end
            advance();
        end
        checks++;
        if (sc4 !== 4'hF || int'(sc) !== sc0 + 20) begin
            errors++;
            $display("[TB] FAIL saturation_count: sc4 %h sc %0d want F %0d", sc4, sc, sc0 + 20);
        end
    endtask

    task automatic test_async_reset();
        set_idle();
        op = 6'b000101; rs = 5'd4; rt = 5'd7;
        idex_mr = 1'b1; idex_rd = 5'd4;
        @(negedge clk);
        predict();
        advance();
        checks++;
        if (st !== 2'b01) begin
            errors++;
            $display("[TB] FAIL async_pre_hold: st %b want 01", st);
        end
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (st !== 2'b00 || obs_cnt() !== 40'd0 || pcw !== 1'b1 || bub !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: st %b cnt %h pcw %b want 00 0 1", st, obs_cnt(), pcw);
        end
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            predict();
            checks++;
            if (pcw !== 1'b1 || st !== 2'b00 || obs_ctrl() !== e_ctrl || obs_cnt() !== e_cnt) begin
                errors++;
                $display("[TB] FAIL async_resume c%0d: ctrl %b cnt %h want %b %h", c, obs_ctrl(), obs_cnt(), e_ctrl, e_cnt);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'b000000, 6'b000100, 6'b000101, 6'b101011,
                6'b000010, 6'b100011, 6'b001000};
        for (int c = 0; c < 400; c++) begin
            op       = ops[$urandom_range(0, 6)];
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            idex_mr  = 1'($urandom_range(0, 1));
            idex_rw  = 1'($urandom_range(0, 1));
            idex_rd  = 5'($urandom_range(0, 3));
            exmem_mr = 1'($urandom_range(0, 1));
            exmem_rd = 5'($urandom_range(0, 3));
            pcsrc    = ($urandom_range(0, 3) == 0);
            isj      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            predict();
            checks++;
            if (obs_ctrl() !== e_ctrl) begin
                errors++;
                $display("[TB] FAIL random_ctrl c%0d: got %b want %b", c, obs_ctrl(), e_ctrl);
            end
            checks++;
            if (obs_cnt() !== e_cnt) begin
                errors++;
                $display("[TB] FAIL random_cnt c%0d: got %h want %h", c, obs_cnt(), e_cnt);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_reg_zero();
        test_jump();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
